// File: rtl/d_interface_pkg.sv
// Shared types for the d_interface serial "1,0,0" pattern detector.
// Holds the FSM state encoding and the pure next-state function.
package d_interface_pkg;

    // Encodings are visible on state_o, so they are pinned explicitly.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        S1   = 2'b01,
        S2   = 2'b10,
        S3   = 2'b11
    } state_t;

    // One step of the detector for a single sampled bit.
    // Any value that is not a legal encoding (X/Z in simulation)
    // falls back to IDLE so the detector always recovers.
    function automatic state_t next_state(input state_t cur,
                                          input logic   bit_in);
        state_t nxt;
        nxt = IDLE;
        case (cur)
            IDLE:    nxt = bit_in ? S1 : IDLE;
            S1:      nxt = bit_in ? S1 : S2;
            S2:      nxt = bit_in ? S1 : S3;
            S3:      nxt = bit_in ? S1 : IDLE;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/d_interface.sv
// Moore detector for the serial pattern 1,0,0 (overlaps allowed) with a
// saturating count of detections.
//   clk       : rising-edge clock
//   reset     : synchronous, active-high; clears state and count
//   s_in      : serial data bit, sampled on rising clk
//   out       : 1 while in S3 (pattern just completed), registered only
//   state_o   : raw state register for observability
//   det_count : entries into S3 since reset, holds at all-ones
module d_interface
    import d_interface_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    output logic             out,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] det_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enter_s3;

    always_comb begin
        state_d  = next_state(state_q, s_in);
        // S3 never self-loops, but the guard keeps the count honest
        // should the transition table ever change.
        enter_s3 = (state_d == S3) && (state_q != S3);
        cnt_d    = cnt_q;
        if (enter_s3 && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Decoded from the register only: no path from s_in to out.
    assign out       = (state_q == S3);
    assign state_o   = state_q;
    assign det_count = cnt_q;

endmodule

// File: tb/tb_d_interface.sv
// Directed testbench for d_interface: reset, single detection, overlap,
// broken pattern, mid-sequence reset and counter saturation (CNT_W=2).
module tb_d_interface;

    logic       clk;
    logic       reset;
    logic       s_in;
    logic       out_a, out_b;
    logic [1:0] st_a, st_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_tests;
    int n_fail;

    d_interface #(.CNT_W(8)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .s_in      (s_in),
        .out       (out_a),
        .state_o   (st_a),
        .det_count (cnt_a)
    );

    d_interface #(.CNT_W(2)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .s_in      (s_in),
        .out       (out_b),
        .state_o   (st_b),
        .det_count (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit, let one rising edge sample it, settle 1 ns.
    task automatic tick(input logic b);
        s_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0);
        n_tests++;
        if (st_a !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=00", st_a);
        end
        n_tests++;
        if (out_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out got=%b exp=0", out_a);
        end
        n_tests++;
        if (cnt_a !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_count got=%0d exp=0", cnt_a);
        end
        n_tests++;
        if (cnt_b !== 2'd0 || st_b !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_dut_b got=%b/%0d exp=00/0", st_b, cnt_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [8:0] bits;
        logic [1:0] exp_st [9];
        int pulses;
        bits = 9'b111000000;
        exp_st = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b11,
                   2'b00, 2'b00, 2'b00, 2'b00};
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            tick(bits[8-i]);
            n_tests++;
            if (st_a !== exp_st[i]) begin
                n_fail++;
                $display("FAIL basic_state[%0d] got=%b exp=%b",
                         i, st_a, exp_st[i]);
            end
            n_tests++;
            if (out_a !== (exp_st[i] == 2'b11)) begin
                n_fail++;
                $display("FAIL basic_out[%0d] got=%b exp=%b",
                         i, out_a, exp_st[i] == 2'b11);
            end
            if (out_a === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL basic_pulses got=%0d exp=1", pulses);
        end
        n_tests++;
        if (cnt_a !== 8'd1) begin
            n_fail++;
            $display("FAIL basic_count got=%0d exp=1", cnt_a);
        end
    endtask

    task automatic test_overlap();
        logic [5:0] bits;
        logic [1:0] exp_st [6];
        int pulses;
        do_reset();
        bits = 6'b100100;
        exp_st = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick(bits[5-i]);
            n_tests++;
            if (st_a !== exp_st[i]) begin
                n_fail++;
                $display("FAIL overlap_state[%0d] got=%b exp=%b",
                         i, st_a, exp_st[i]);
            end
            if (out_a === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL overlap_pulses got=%0d exp=2", pulses);
        end
        n_tests++;
        if (cnt_a !== 8'd2) begin
            n_fail++;
            $display("FAIL overlap_count got=%0d exp=2", cnt_a);
        end
    endtask

    task automatic test_broken();
        logic [4:0] bits;
        logic [1:0] exp_st [5];
        int pulses;
        do_reset();
        bits = 5'b10100;
        exp_st = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b11};
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick(bits[4-i]);
            n_tests++;
            if (st_a !== exp_st[i]) begin
                n_fail++;
                $display("FAIL broken_state[%0d] got=%b exp=%b",
                         i, st_a, exp_st[i]);
            end
            if (out_a === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 1 || cnt_a !== 8'd1) begin
            n_fail++;
            $display("FAIL broken_pulse_count got=%0d/%0d exp=1/1",
                     pulses, cnt_a);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(1'b1);
        tick(1'b0);
        n_tests++;
        if (st_a !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_pre_state got=%b exp=10", st_a);
        end
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        n_tests++;
        if (st_a !== 2'b00 || out_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got=%b/%b exp=00/0", st_a, out_a);
        end
        tick(1'b0);
        n_tests++;
        if (st_a !== 2'b00 || out_a !== 1'b0 || cnt_a !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_after got=%b/%b/%0d exp=00/0/0",
                     st_a, out_a, cnt_a);
        end
        // Reset must win over s_in=1 as well.
        tick(1'b1);
        reset = 1'b1;
        tick(1'b1);
        reset = 1'b0;
        n_tests++;
        if (st_a !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_override got=%b exp=00", st_a);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_b [5];
        exp_b = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick(1'b1);
            tick(1'b0);
            tick(1'b0);
            n_tests++;
            if (out_b !== 1'b1 || cnt_b !== exp_b[k]) begin
                n_fail++;
                $display("FAIL sat_det[%0d] got=%b/%0d exp=1/%0d",
                         k, out_b, cnt_b, exp_b[k]);
            end
        end
        n_tests++;
        if (cnt_a !== 8'd5) begin
            n_fail++;
            $display("FAIL sat_wide_count got=%0d exp=5", cnt_a);
        end
        tick(1'b0);
        n_tests++;
        if (cnt_b !== 2'd3 || out_b !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_hold got=%0d/%b exp=3/0", cnt_b, out_b);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        s_in    = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_broken();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
